// File: rtl/pipe_mac_arbiter.sv
// Two-requester round-robin front end for the shared 4-stage multiply-add pipeline.
// Tags each issued operation so the result is routed back to its requester.
module pipe_mac_arbiter #(
  parameter int DW      = 8,
  parameter int RW      = 16,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req0_c,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [DW-1:0] req1_c,
  output logic [DW-1:0] pipe_a,
  output logic [DW-1:0] pipe_b,
  output logic [DW-1:0] pipe_c,
  input  logic [RW-1:0] pipe_g,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [RW-1:0] rsp_data,
  output logic          idle
);

  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  state_t             state;
  state_t             state_nxt;
  tag_t [LATENCY:0]   tags;
  tag_t               tag_in;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      inflight_nxt;
  logic               last_grant;
  logic               issue;
  logic               gnt_id;
  logic               retire;

  // Ties go to whichever requester was not granted last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && !hold) begin
      unique case ({req1_valid, req0_valid})
        2'b11: begin
          req0_ready = last_grant;
          req1_ready = ~last_grant;
        end
        2'b01:   req0_ready = 1'b1;
        2'b10:   req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign issue      = req0_ready | req1_ready;
  assign gnt_id     = req1_ready;
  assign retire     = tags[LATENCY].vld;
  assign tag_in.vld = issue;
  assign tag_in.id  = gnt_id;

  always_comb begin
    inflight_nxt = inflight;
    unique case ({issue, retire})
      2'b10:   inflight_nxt = inflight + ONE;
      2'b01:   inflight_nxt = inflight - ONE;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (issue) state_nxt = RUN;
      end
      RUN: begin
        if (inflight_nxt == '0) state_nxt = IDLE;
        else if (hold)          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight_nxt == '0) state_nxt = IDLE;
        else if (!hold)         state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tags       <= '0;
      inflight   <= '0;
      last_grant <= 1'b1;
      pipe_a     <= '0;
      pipe_b     <= '0;
      pipe_c     <= '0;
    end else begin
      state    <= state_nxt;
      tags     <= {tags[LATENCY-1:0], tag_in};
      inflight <= inflight_nxt;
      pipe_a   <= issue ? (gnt_id ? req1_a : req0_a) : '0;
      pipe_b   <= issue ? (gnt_id ? req1_b : req0_b) : '0;
      pipe_c   <= issue ? (gnt_id ? req1_c : req0_c) : '0;
      if (issue) last_grant <= gnt_id;
    end
  end

  assign rsp0_valid = retire & ~tags[LATENCY].id;
  assign rsp1_valid = retire &  tags[LATENCY].id;
  assign rsp_data   = pipe_g;
  assign idle       = (state == IDLE) & ~issue;

endmodule
